// File: rtl/tilt_motion_ctl_if.sv
// Tilt-to-motion bundle: tilt/freeze controls in, step strobes,
// positions, velocities and wall hits out.
interface tilt_motion_ctl_if;
   logic [3:0] tilt;
   logic       freeze;
   logic       x_inc;
   logic       x_dec;
   logic       y_inc;
   logic       y_dec;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic [3:0] vel_x;
   logic [3:0] vel_y;
   logic [3:0] wall;

   modport master (
      output tilt, freeze,
      input  x_inc, x_dec, y_inc, y_dec,
      input  x_pos, y_pos, vel_x, vel_y, wall
   );

   modport slave (
      input  tilt, freeze,
      output x_inc, x_dec, y_inc, y_dec,
      output x_pos, y_pos, vel_x, vel_y, wall
   );
endinterface

// File: rtl/tilt_motion_ctl.sv
// Tilt code to ball motion: per-axis ramping velocity, phase
// accumulator stepping, bounded position and wall-hit strobes.
module tilt_motion_ctl #(
   parameter int SYSCLK_FREQUENCY_HZ = 100000000,
   parameter int TICK_HZ             = 1000,
   parameter int ACCEL_TICKS         = 50,
   parameter int MAX_SPEED           = 7,
   parameter int STEP_THRESH         = 8,
   parameter int POS_MAX             = 639,
   parameter int X_INIT              = 320,
   parameter int Y_INIT              = 240
) (
   input  logic SYSCLK,
   input  logic reset2,
   tilt_motion_ctl_if.slave bus
);

   localparam int TICK_DIV = SYSCLK_FREQUENCY_HZ / TICK_HZ;
   localparam int CW = $clog2(TICK_DIV);
   localparam int AW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_TICKS - 1);
   localparam logic [3:0] VMAX = 4'(MAX_SPEED);
   localparam logic [3:0] VMIN = 4'(-MAX_SPEED);
   localparam logic [4:0] THR  = 5'(STEP_THRESH);
   localparam logic [9:0] PMAX = 10'(POS_MAX);

   typedef struct packed {
      logic [3:0] v;
      logic [3:0] ph;
      logic [9:0] pos;
   } axis_t;

   typedef struct packed {
      axis_t st;
      logic  inc;
      logic  dec;
      logic  wlo;
      logic  whi;
   } axis_res_t;

   // Stepping uses the velocity held before this tick's update.
   function automatic axis_res_t axis_next(
      axis_t cur, logic neg, logic posd, logic vupd
   );
      axis_res_t  r;
      logic [3:0] absv;
      logic [3:0] vn;
      logic [4:0] s;
      logic [4:0] rem;
      logic       vneg;
      logic       vpos;
      r      = '0;
      r.st   = cur;
      vneg   = cur.v[3];
      vpos   = !cur.v[3] && (cur.v != 4'd0);
      absv   = vneg ? (4'd0 - cur.v) : cur.v;
      s      = {1'b0, cur.ph} + {1'b0, absv};
      rem    = s - THR;
      vn     = cur.v;
      if (vupd) begin
         if (posd && !neg)
            vn = (cur.v == VMAX) ? cur.v : cur.v + 4'd1;
         else if (neg && !posd)
            vn = (cur.v == VMIN) ? cur.v : cur.v - 4'd1;
         else if (vpos)
            vn = cur.v - 4'd1;
         else if (vneg)
            vn = cur.v + 4'd1;
      end
      r.st.v = vn;
      if (cur.v != 4'd0) begin
         if (s >= THR) begin
            if (vpos && cur.pos == PMAX) begin
               r.st.v  = 4'd0;
               r.st.ph = 4'd0;
               r.whi   = 1'b1;
            end else if (vneg && cur.pos == 10'd0) begin
               r.st.v  = 4'd0;
               r.st.ph = 4'd0;
               r.wlo   = 1'b1;
            end else begin
               r.st.ph = rem[3:0];
               if (vpos) begin
                  r.st.pos = cur.pos + 10'd1;
                  r.inc    = 1'b1;
               end else begin
                  r.st.pos = cur.pos - 10'd1;
                  r.dec    = 1'b1;
               end
            end
         end else begin
            r.st.ph = s[3:0];
         end
      end
      return r;
   endfunction

   logic [CW-1:0] presc_q, presc_d;
   logic [AW-1:0] acc_q, acc_d;
   axis_t         x_q, x_d;
   axis_t         y_q, y_d;
   logic          xinc_q, xinc_d;
   logic          xdec_q, xdec_d;
   logic          yinc_q, yinc_d;
   logic          ydec_q, ydec_d;
   logic [3:0]    wall_q, wall_d;

   logic      tick;
   logic      run;
   logic      vupd;
   axis_res_t xr;
   axis_res_t yr;

   always_comb begin
      tick    = (presc_q == DIV_LAST);
      presc_d = tick ? '0 : presc_q + CW'(1);
      run     = tick && !bus.freeze;
      vupd    = run && (acc_q == ACC_LAST);
      acc_d   = acc_q;
      if (run)
         acc_d = (acc_q == ACC_LAST) ? '0 : acc_q + AW'(1);
      xr     = axis_next(x_q, bus.tilt[0], bus.tilt[1], vupd);
      yr     = axis_next(y_q, bus.tilt[2], bus.tilt[3], vupd);
      x_d    = x_q;
      y_d    = y_q;
      xinc_d = 1'b0;
      xdec_d = 1'b0;
      yinc_d = 1'b0;
      ydec_d = 1'b0;
      wall_d = 4'd0;
      if (run) begin
         x_d    = xr.st;
         y_d    = yr.st;
         xinc_d = xr.inc;
         xdec_d = xr.dec;
         yinc_d = yr.inc;
         ydec_d = yr.dec;
         wall_d = {yr.whi, yr.wlo, xr.whi, xr.wlo};
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (!reset2) begin
         presc_q <= '0;
         acc_q   <= '0;
         x_q     <= '{v: 4'd0, ph: 4'd0, pos: 10'(X_INIT)};
         y_q     <= '{v: 4'd0, ph: 4'd0, pos: 10'(Y_INIT)};
         xinc_q  <= 1'b0;
         xdec_q  <= 1'b0;
         yinc_q  <= 1'b0;
         ydec_q  <= 1'b0;
         wall_q  <= 4'd0;
      end else begin
         presc_q <= presc_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xinc_q  <= xinc_d;
         xdec_q  <= xdec_d;
         yinc_q  <= yinc_d;
         ydec_q  <= ydec_d;
         wall_q  <= wall_d;
      end
   end

   assign bus.x_inc = xinc_q;
   assign bus.x_dec = xdec_q;
   assign bus.y_inc = yinc_q;
   assign bus.y_dec = ydec_q;
   assign bus.x_pos = x_q.pos;
   assign bus.y_pos = y_q.pos;
   assign bus.vel_x = x_q.v;
   assign bus.vel_y = y_q.v;
   assign bus.wall  = wall_q;

endmodule
